// File: rtl/cgra_cfg_sequencer.sv
// Configuration/run sequencer between the DMA word stream and the CGRA PE array.
// Optional RUN watchdog enabled by defining CGRA_RUN_TIMEOUT_EN.
module cgra_cfg_sequencer #(
  parameter int NUM_PE         = 4,
  parameter int PE_IDX_W       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                cfg_we,
  output logic [PE_IDX_W-1:0] cfg_pe,
  output logic                cfg_kind,
  output logic [5:0]          cfg_data,
  output logic                pe_start,
  output logic [5:0]          pe_operand,
  input  logic                pe_done,
  input  logic [7:0]          pe_result,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                err,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    ST_CFG   = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [1:0] T_WEIGHT = 2'd0;
  localparam logic [1:0] T_CONFIG = 2'd1;
  localparam logic [1:0] T_START  = 2'd2;
  localparam logic [1:0] T_END    = 2'd3;
  localparam logic [PE_IDX_W-1:0] LAST_PE = PE_IDX_W'(NUM_PE - 1);

  if (NUM_PE < 2 || NUM_PE > 16 || PE_IDX_W != $clog2(NUM_PE) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cgra_cfg_sequencer: illegal parameter combination");
  end

  state_t                state_q, state_d;
  logic [PE_IDX_W-1:0]   pe_ptr_q, pe_ptr_d;
  logic                  in_valid_q;
  logic [7:0]            result_q, result_d;
  logic                  err_q, err_d;
  logic                  cfg_we_q, cfg_we_d;
  logic [PE_IDX_W-1:0]   cfg_pe_q, cfg_pe_d;
  logic                  cfg_kind_q, cfg_kind_d;
  logic [5:0]            cfg_data_q, cfg_data_d;
  logic                  pe_start_q, pe_start_d;
  logic [5:0]            pe_operand_q, pe_operand_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  accept_s;
  logic [1:0]            word_type_s;

`ifdef CGRA_RUN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
`endif

  // A held wr_en level yields a single accepted word on its rising edge.
  assign accept_s    = in_valid & ~in_valid_q;
  assign word_type_s = in_data[7:6];

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    pe_ptr_d     = pe_ptr_q;
    result_d     = result_q;
    err_d        = err_q;
    cfg_we_d     = 1'b0;
    cfg_pe_d     = cfg_pe_q;
    cfg_kind_d   = cfg_kind_q;
    cfg_data_d   = cfg_data_q;
    pe_start_d   = 1'b0;
    pe_operand_d = pe_operand_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
`ifdef CGRA_RUN_TIMEOUT_EN
    run_cnt_d    = run_cnt_q;
`endif
    case (state_q)
      ST_CFG, ST_READY: begin
        if (accept_s) begin
          case (word_type_s)
            T_WEIGHT: begin
              cfg_we_d   = 1'b1;
              cfg_pe_d   = pe_ptr_q;
              cfg_kind_d = 1'b0;
              cfg_data_d = in_data[5:0];
            end
            T_CONFIG: begin
              cfg_we_d   = 1'b1;
              cfg_pe_d   = pe_ptr_q;
              cfg_kind_d = 1'b1;
              cfg_data_d = in_data[5:0];
              // Wrapping past the last PE completes a full configuration pass.
              if (pe_ptr_q == LAST_PE) begin
                pe_ptr_d = '0;
                state_d  = ST_READY;
              end else begin
                pe_ptr_d = pe_ptr_q + PE_IDX_W'(1);
              end
            end
            T_START: begin
              if (state_q == ST_READY) begin
                pe_start_d   = 1'b1;
                pe_operand_d = in_data[5:0];
                state_d      = ST_RUN;
`ifdef CGRA_RUN_TIMEOUT_EN
                run_cnt_d    = '0;
`endif
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          err_d = err_q;
        end
      end
      ST_RUN: begin
        err_d = err_q | accept_s;
        if (pe_done) begin
          result_d = pe_result;
          state_d  = ST_DONE;
        end else begin
`ifdef CGRA_RUN_TIMEOUT_EN
          if (run_cnt_q == CNT_LAST) begin
            err_d    = 1'b1;
            result_d = 8'hFF;
            state_d  = ST_DONE;
          end else begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          if (word_type_s == T_END) begin
            out_valid_d = 1'b1;
            out_data_d  = result_q;
            state_d     = ST_OUT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = err_q;
        end
      end
      ST_OUT: begin
        err_d = err_q | accept_s;
        if (out_valid_q & out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_READY;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CFG;
      pe_ptr_q     <= '0;
      in_valid_q   <= 1'b0;
      result_q     <= 8'h00;
      err_q        <= 1'b0;
      cfg_we_q     <= 1'b0;
      cfg_pe_q     <= '0;
      cfg_kind_q   <= 1'b0;
      cfg_data_q   <= 6'h00;
      pe_start_q   <= 1'b0;
      pe_operand_q <= 6'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
`ifdef CGRA_RUN_TIMEOUT_EN
      run_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pe_ptr_q     <= pe_ptr_d;
      in_valid_q   <= in_valid;
      result_q     <= result_d;
      err_q        <= err_d;
      cfg_we_q     <= cfg_we_d;
      cfg_pe_q     <= cfg_pe_d;
      cfg_kind_q   <= cfg_kind_d;
      cfg_data_q   <= cfg_data_d;
      pe_start_q   <= pe_start_d;
      pe_operand_q <= pe_operand_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
`ifdef CGRA_RUN_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
`endif
    end
  end

  assign cfg_we     = cfg_we_q;
  assign cfg_pe     = cfg_pe_q;
  assign cfg_kind   = cfg_kind_q;
  assign cfg_data   = cfg_data_q;
  assign pe_start   = pe_start_q;
  assign pe_operand = pe_operand_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err        = err_q;
  assign busy       = (state_q == ST_RUN) | (state_q == ST_OUT);
  assign state_o    = state_q;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// phase-level reference model of the sequencer.
module tb_cgra_cfg_sequencer;
  localparam int NPE = 4;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, pe_done, out_ready;
  logic [7:0] in_data, pe_result;
  logic       cfg_we, cfg_kind, pe_start, out_valid, busy, err;
  logic [1:0] cfg_pe;
  logic [5:0] cfg_data, pe_operand;
  logic [7:0] out_data;
  logic [2:0] state_o;

  cgra_cfg_sequencer #(.NUM_PE(NPE), .PE_IDX_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_pe(cfg_pe), .cfg_kind(cfg_kind), .cfg_data(cfg_data),
    .pe_start(pe_start), .pe_operand(pe_operand), .pe_done(pe_done),
    .pe_result(pe_result), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: phases 0=CFG 1=READY 2=RUN 3=DONE 4=OUT
  int m_phase, m_ptr, m_prev, m_result, m_err, m_we, m_pe, m_kind, m_cdata;
  int m_start, m_oper, m_ov, m_od, m_runlen;

  function automatic void m_reset();
    m_phase = 0; m_ptr = 0; m_prev = 0; m_result = 0; m_err = 0;
    m_we = 0; m_pe = 0; m_kind = 0; m_cdata = 0; m_start = 0; m_oper = 0;
    m_ov = 0; m_od = 0; m_runlen = 0;
  endfunction

  function automatic void m_clock(int iv, int d, int done, int res, int rdy);
    int acc, ty;
    acc = (iv != 0 && m_prev == 0) ? 1 : 0;
    m_prev = iv;
    ty = d / 64;
    m_we = 0;
    m_start = 0;
    if (m_phase == 0 || m_phase == 1) begin
      if (acc != 0) begin
        if (ty == 0 || ty == 1) begin
          m_we = 1; m_pe = m_ptr; m_kind = ty; m_cdata = d % 64;
          if (ty == 1) begin
            m_ptr = m_ptr + 1;
            if (m_ptr == NPE) begin m_ptr = 0; m_phase = 1; end
          end
        end else if (ty == 2 && m_phase == 1) begin
          m_start = 1; m_oper = d % 64; m_phase = 2; m_runlen = 0;
        end else m_err = 1;
      end
    end else if (m_phase == 2) begin
      if (acc != 0) m_err = 1;
      if (done != 0) begin
        m_result = res; m_phase = 3;
      end else begin
`ifdef CGRA_RUN_TIMEOUT_EN
        m_runlen = m_runlen + 1;
        if (m_runlen == TO) begin m_err = 1; m_result = 255; m_phase = 3; end
`endif
      end
    end else if (m_phase == 3) begin
      if (acc != 0) begin
        if (ty == 3) begin m_ov = 1; m_od = m_result; m_phase = 4; end
        else m_err = 1;
      end
    end else begin
      if (acc != 0) m_err = 1;
      if (m_ov != 0 && rdy != 0) begin m_ov = 0; m_phase = 1; end
    end
  endfunction

  task automatic compare_all();
    chk("cfg_we", cfg_we, m_we);
    chk("cfg_pe", cfg_pe, m_pe);
    chk("cfg_kind", cfg_kind, m_kind);
    chk("cfg_data", cfg_data, m_cdata);
    chk("pe_start", pe_start, m_start);
    chk("pe_operand", pe_operand, m_oper);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("err", err, m_err);
    chk("state_o", state_o, m_phase);
    chk("busy", busy, (m_phase == 2 || m_phase == 4) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    m_clock(in_valid, in_data, pe_done, pe_result, out_ready);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; pe_done = 1'b0; out_ready = 1'b0;
    #2;
    m_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press(input logic [7:0] w);
    in_valid = 1'b1; in_data = w; step();
  endtask

  task automatic release_word();
    in_valid = 1'b0; step();
  endtask

  task automatic cfg_all();
    for (int p = 0; p < NPE; p++) begin
      press(8'h05);
      chk("w_we", cfg_we, 1); chk("w_pe", cfg_pe, p); chk("w_kind", cfg_kind, 0);
      release_word();
      chk("w_we_clr", cfg_we, 0);
      press(8'h46);
      chk("c_we", cfg_we, 1); chk("c_kind", cfg_kind, 1); chk("c_data", cfg_data, 6'h06);
      release_word();
    end
    chk("ready_after_cfg", state_o, 1);
  endtask

  initial begin
    int pulses, ty;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    pe_done = 1'b0; pe_result = 8'h00; out_ready = 1'b0;
    do_reset();
    chk("rst_state", state_o, 0);
    cfg_all();

    // held wr_en yields one write
    pulses = 0;
    in_valid = 1'b1; in_data = 8'h3F;
    for (int i = 0; i < 5; i++) begin step(); pulses += cfg_we; end
    chk("held_pulses", pulses, 1);
    release_word();

    press(8'h8A);
    chk("start", pe_start, 1); chk("operand", pe_operand, 6'h0A); chk("busy_run", busy, 1);
    release_word();
    chk("start_clr", pe_start, 0);
    pe_done = 1'b1; pe_result = 8'h5C; step(); pe_done = 1'b0;
    chk("done_state", state_o, 3);
    press(8'hC0);
    chk("ov", out_valid, 1); chk("od", out_data, 8'h5C);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); chk("od_hold", out_data, 8'h5C); chk("ov_hold", out_valid, 1); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("ov_drop", out_valid, 0); chk("back_ready", state_o, 1);

    // protocol errors
    do_reset();
    pe_done = 1'b1; step(); pe_done = 1'b0;
    chk("done_ignored", err, 0);
    press(8'h80);
    chk("err_cfg_start", err, 1); chk("no_start", pe_start, 0); chk("cfg_stay", state_o, 0);
    release_word();
    do_reset();
    cfg_all();
    press(8'h81); release_word();
    press(8'h01);
    chk("err_run_w", err, 1); chk("no_we", cfg_we, 0); chk("run_stay", state_o, 2);
    release_word();
    pe_done = 1'b1; pe_result = 8'h33; step(); pe_done = 1'b0;
    chk("err_sticky", err, 1);

`ifdef CGRA_RUN_TIMEOUT_EN
    do_reset();
    cfg_all();
    press(8'h81); release_word();
    for (int i = 0; i < TO - 1; i++) step();
    chk("to_state", state_o, 3); chk("to_err", err, 1);
    press(8'hC0);
    chk("to_od", out_data, 8'hFF);
    release_word();
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) do_reset();
      in_valid = 1'($urandom_range(0, 1));
      ty = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (m_phase == 0) ty = $urandom_range(0, 1);
        else if (m_phase == 1) ty = $urandom_range(0, 2);
        else if (m_phase == 3) ty = 3;
      end
      in_data = {2'(ty), 6'($urandom_range(0, 63))};
      pe_done = ($urandom_range(0, 9) == 0);
      pe_result = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
